parity_page_reader: RTL and testbench
=====================================

# parity_page_reader

Read-side sequencer for the encoder's column-parity step. It reads 25-bit pages from the page memory and presents each page to the parity datapath together with its predecessor. The predecessor of page 0 is page PAGE_COUNT-1. For every page it sweeps all 25 cells, driving the column indices x_prev/x_cur/x_next and the row index y_cur. It sits between the page memory read port and the parity datapath, which consumes cur_page, prev_page and the indices.

## Interface
- PAGE_COUNT, 64, number of pages per block; legal range 2..2^ADDR_W
- ADDR_W, 6, page memory address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a block pass; sampled only in IDLE
- mem_rd_en  out  1  page memory read strobe
- mem_addr  out  ADDR_W  page address, valid with mem_rd_en
- mem_rd_data  in  [0:24]  page data; valid exactly one cycle after mem_rd_en
- cur_page  out  [0:24]  current page register
- prev_page  out  [0:24]  predecessor page register
- x_prev, x_cur, x_next  out  3 each  column indices; x_prev=(x_cur+4) mod 5, x_next=(x_cur+1) mod 5
- y_cur  out  3  row index 0..4
- cell_valid  out  1  indices and pages are valid for the datapath this cycle
- page_done  out  1  high on the last cell (x=4, y=4) of each page
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass completes

## Operation
- States:
  - IDLE: start=1 goes to PREV_REQ.
  - PREV_REQ: mem_rd_en=1, mem_addr=PAGE_COUNT-1.
  - PREV_WAIT: prev_page<=mem_rd_data.
  - CUR_REQ: mem_rd_en=1, mem_addr=page index.
  - CUR_WAIT: cur_page<=mem_rd_data.
  - SWEEP: 25 cycles.
  - DONE: done=1, then IDLE.
- SWEEP cell order: y_cur outer 0..4, x_cur inner 0..4, one cell per cycle, cell_valid=1.
- Index arithmetic is mod 5 on 3-bit values and never produces 5..7.
- End of a page:
  - prev_page<=cur_page.
  - The page index increments.
  - If the page index was PAGE_COUNT-1, go to DONE; otherwise go to CUR_REQ.
- The page index counts 0..PAGE_COUNT-1 and never wraps within a pass.
- Memory is read only in REQ states (plus the prefetch slot, see Configuration). mem_rd_data is ignored in all other cycles.
- start while busy is ignored and does not queue.
- Reset values:
  - state=IDLE; all outputs 0 except x_prev=4 and x_next=1 (consistent with x_cur=0).
  - cur_page=prev_page=0; mem_addr=0.
- rst mid-pass: returns to IDLE on the next edge and drops any outstanding read. No done pulse is produced. A subsequent start runs a full pass from the beginning.

## Timing
- start is sampled high in IDLE at edge 0.
- Without prefetch:
  - PREV_REQ in cycle 1, PREV_WAIT in cycle 2.
  - Each page takes 27 cycles (REQ, WAIT, 25 SWEEP).
  - done pulses in cycle 3+27·PAGE_COUNT.
- With prefetch:
  - Page 0 timing is identical.
  - Later pages take 25 cycles each.
  - done pulses in cycle 30+25·(PAGE_COUNT-1).
- cell_valid, indices, cur_page and prev_page are registered and change only on clock edges. They are stable for the whole cycle in which cell_valid=1.
- page_done coincides with cell_valid on cell (4,4).
- busy rises the cycle after start is sampled and falls the cycle after done.

## Configuration
- PARITY_READER_PREFETCH_EN defined:
  - On SWEEP cell 23 of page p < PAGE_COUNT-1, issue mem_rd_en with mem_addr=p+1.
  - Capture the returning data into a staging register at the end of cell 24.
  - At the page boundary: cur_page<=stage and prev_page<=cur_page. SWEEP continues without a gap, so cell_valid stays high across pages.
  - No prefetch is issued during the last page.
- PARITY_READER_PREFETCH_EN undefined:
  - No staging register.
  - Every page goes through CUR_REQ/CUR_WAIT, giving a 2-cycle cell_valid gap between pages.

## Test plan
- Full pass, PAGE_COUNT=4, page k holds 25'h0000001<<k, no prefetch -> read address sequence 3,0,1,2,3. Page 0 is swept with prev_page=page 3. 100 cell_valid cycles in row-major order. done at cycle 111.
- Same pass with PARITY_READER_PREFETCH_EN -> identical cur/prev/index stream per cell. cell_valid continuous from cycle 5 to 104. done at cycle 105.
- Index check over one page -> (x_prev,x_cur,x_next) equals (4,0,1) at x=0 and (3,4,0) at x=4. page_done only on cell (4,4).
- start pulsed during SWEEP of page 1 -> no effect on the address sequence; exactly one done pulse.
- rst asserted in SWEEP of page 2, cell 10 -> next cycle: IDLE, busy=0, cell_valid=0, x_prev=4, pages zero. A new start reproduces the full first-test stream.
- PAGE_COUNT=2, random page data -> page 0 is paired with prev=page 1, and page 1 is paired with prev=page 0.

Source files
------------

// File: rtl/parity_page_reader.sv
`default_nettype none
// ============================================================================
// Module   : parity_page_reader
// Purpose  : Read-side sequencer for the column-parity step. Fetches 25-bit
//            pages from the page memory and presents each page together with
//            its predecessor (page 0 is paired with page PAGE_COUNT-1),
//            sweeping all 25 cells (y outer, x inner) with the column indices
//            x_prev/x_cur/x_next and the row index y_cur.
// Ports    : clk, rst (sync, active-high), start
//            mem_rd_en / mem_addr / mem_rd_data : page memory read port
//                                                 (data returns 1 cycle later)
//            cur_page, prev_page                : page registers for datapath
//            x_prev, x_cur, x_next, y_cur       : cell indices (mod 5)
//            cell_valid, page_done              : per-cell qualifiers
//            busy, done                         : pass status
// Config   : PARITY_READER_PREFETCH_EN -- when defined, the next page is read
//            during cells 23/24 so the sweep runs without gaps between pages.
// Revision : 1.0 - initial release
// ============================================================================
module parity_page_reader #(
   parameter int PAGE_COUNT = 64,
   parameter int ADDR_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [0:24]       mem_rd_data,
   output logic [0:24]       cur_page,
   output logic [0:24]       prev_page,
   output logic [2:0]        x_prev,
   output logic [2:0]        x_cur,
   output logic [2:0]        x_next,
   output logic [2:0]        y_cur,
   output logic              cell_valid,
   output logic              page_done,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PREV_REQ  = 3'd1,
      ST_PREV_WAIT = 3'd2,
      ST_CUR_REQ   = 3'd3,
      ST_CUR_WAIT  = 3'd4,
      ST_SWEEP     = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(PAGE_COUNT - 1);

   state_t            state;
   logic [ADDR_W-1:0] page_idx;

   logic last_cell;
   logic last_page;

   assign last_cell = (x_cur == 3'd4) && (y_cur == 3'd4);
   assign last_page = (page_idx == LAST_PAGE);

   // Increment modulo 5; never yields 5..7 for legal inputs.
   function automatic logic [2:0] inc5(input logic [2:0] v);
      return (v == 3'd4) ? 3'd0 : v + 3'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         page_idx   <= '0;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         cur_page   <= '0;
         prev_page  <= '0;
         x_prev     <= 3'd4;
         x_cur      <= 3'd0;
         x_next     <= 3'd1;
         y_cur      <= 3'd0;
         cell_valid <= 1'b0;
         page_done  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         mem_rd_en <= 1'b0;
         done      <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_PREV_REQ;
                  busy      <= 1'b1;
                  page_idx  <= '0;
                  mem_rd_en <= 1'b1;
                  mem_addr  <= LAST_PAGE;
               end
            end

            ST_PREV_REQ: begin
               state <= ST_PREV_WAIT;
            end

            ST_PREV_WAIT: begin
               prev_page <= mem_rd_data;
               state     <= ST_CUR_REQ;
               mem_rd_en <= 1'b1;
               mem_addr  <= page_idx;
            end

            ST_CUR_REQ: begin
               state <= ST_CUR_WAIT;
            end

            ST_CUR_WAIT: begin
               cur_page   <= mem_rd_data;
               state      <= ST_SWEEP;
               cell_valid <= 1'b1;
               x_prev     <= 3'd4;
               x_cur      <= 3'd0;
               x_next     <= 3'd1;
               y_cur      <= 3'd0;
               page_done  <= 1'b0;
            end

            ST_SWEEP: begin
               if (last_cell) begin
                  // Page boundary: current page becomes the predecessor.
                  prev_page <= cur_page;
                  page_idx  <= page_idx + 1'b1;
                  x_prev    <= 3'd4;
                  x_cur     <= 3'd0;
                  x_next    <= 3'd1;
                  y_cur     <= 3'd0;
                  page_done <= 1'b0;
                  if (last_page) begin
                     state      <= ST_DONE;
                     cell_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
`ifdef PARITY_READER_PREFETCH_EN
                     // The prefetched page returns during cell 24; its
                     // staging edge is the page boundary itself, so it is
                     // loaded straight into cur_page and the sweep continues.
                     cur_page <= mem_rd_data;
`else
                     state      <= ST_CUR_REQ;
                     cell_valid <= 1'b0;
                     mem_rd_en  <= 1'b1;
                     mem_addr   <= page_idx + 1'b1;
`endif
                  end
               end else begin
                  if (x_cur == 3'd4) begin
                     x_prev <= 3'd4;
                     x_cur  <= 3'd0;
                     x_next <= 3'd1;
                     y_cur  <= inc5(y_cur);
                  end else begin
                     x_prev <= x_cur;
                     x_cur  <= inc5(x_cur);
                     x_next <= inc5(inc5(x_cur));
                  end
                  // Next cell is (4,4) when the current one is (3,4).
                  page_done <= (x_cur == 3'd3) && (y_cur == 3'd4);
`ifdef PARITY_READER_PREFETCH_EN
                  // Registered strobe: set on cell 22 so it is high in cell 23.
                  if ((x_cur == 3'd2) && (y_cur == 3'd4) && !last_page) begin
                     mem_rd_en <= 1'b1;
                     mem_addr  <= page_idx + 1'b1;
                  end
`endif
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parity_page_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_page_reader
// Purpose  : Self-checking bench for parity_page_reader. Two instances are
//            used: PAGE_COUNT=4 (ADDR_W=3) and PAGE_COUNT=2 (ADDR_W=1). A
//            reference model derives the expected read addresses, cell stream
//            and timing from page number / cell number arithmetic.
// Config   : honours PARITY_READER_PREFETCH_EN for expected timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_page_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start;
   logic sel;          // 0: instance A (4 pages), 1: instance B (2 pages)
   int   checks;
   int   errors;

   wire start_a = start & ~sel;
   wire start_b = start & sel;

   logic        rd_en_a, cv_a, pd_a, busy_a, done_a;
   logic [2:0]  addr_a, xp_a, xc_a, xn_a, y_a;
   logic [0:24] rdata_a, cur_a, prev_a;

   logic        rd_en_b, cv_b, pd_b, busy_b, done_b;
   logic [0:0]  addr_b;
   logic [2:0]  xp_b, xc_b, xn_b, y_b;
   logic [0:24] rdata_b, cur_b, prev_b;

   parity_page_reader #(.PAGE_COUNT(4), .ADDR_W(3)) dut_a (
      .clk(clk), .rst(rst), .start(start_a),
      .mem_rd_en(rd_en_a), .mem_addr(addr_a), .mem_rd_data(rdata_a),
      .cur_page(cur_a), .prev_page(prev_a),
      .x_prev(xp_a), .x_cur(xc_a), .x_next(xn_a), .y_cur(y_a),
      .cell_valid(cv_a), .page_done(pd_a), .busy(busy_a), .done(done_a)
   );

   parity_page_reader #(.PAGE_COUNT(2), .ADDR_W(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b),
      .mem_rd_en(rd_en_b), .mem_addr(addr_b), .mem_rd_data(rdata_b),
      .cur_page(cur_b), .prev_page(prev_b),
      .x_prev(xp_b), .x_cur(xc_b), .x_next(xn_b), .y_cur(y_b),
      .cell_valid(cv_b), .page_done(pd_b), .busy(busy_b), .done(done_b)
   );

   // Page memories: one-cycle read latency, garbage when not reading.
   logic [0:24] mem_a [4];
   logic [0:24] mem_b [2];

   always @(posedge clk) begin
      if (rd_en_a && addr_a < 3'd4) rdata_a <= mem_a[addr_a[1:0]];
      else                          rdata_a <= 25'($urandom);
      if (rd_en_b)                  rdata_b <= mem_b[addr_b];
      else                          rdata_b <= 25'($urandom);
   end

   // Observed signals of the selected instance.
   logic        o_en, o_cv, o_pd, o_busy, o_done;
   logic [0:24] o_cur, o_prev;
   logic [2:0]  o_xp, o_xc, o_xn, o_y;
   int          o_addr;

   always_comb begin
      o_en = rd_en_a; o_cv = cv_a; o_pd = pd_a; o_busy = busy_a; o_done = done_a;
      o_cur = cur_a; o_prev = prev_a; o_xp = xp_a; o_xc = xc_a; o_xn = xn_a; o_y = y_a;
      o_addr = int'(addr_a);
      if (sel) begin
         o_en = rd_en_b; o_cv = cv_b; o_pd = pd_b; o_busy = busy_b; o_done = done_b;
         o_cur = cur_b; o_prev = prev_b; o_xp = xp_b; o_xc = xc_b; o_xn = xn_b; o_y = y_b;
         o_addr = int'(addr_b);
      end
   end

   function automatic logic [0:24] get_page(input int p);
      if (sel) return mem_b[p % 2];
      return mem_a[p % 4];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input bit with_addr);
      chk({tag, ".busy"},  o_busy, 0);
      chk({tag, ".cv"},    o_cv, 0);
      chk({tag, ".pd"},    o_pd, 0);
      chk({tag, ".done"},  o_done, 0);
      chk({tag, ".rd_en"}, o_en, 0);
      chk({tag, ".xp"},    o_xp, 4);
      chk({tag, ".xc"},    o_xc, 0);
      chk({tag, ".xn"},    o_xn, 1);
      chk({tag, ".y"},     o_y, 0);
      chk({tag, ".cur"},   o_cur, 0);
      chk({tag, ".prev"},  o_prev, 0);
      if (with_addr) chk({tag, ".addr"}, o_addr, 0);
   endtask

   // inject: 0 none, 1 start pulse during page 1 sweep, 2 rst at page 2 cell 10
   task automatic run_pass(input int inject);
      int pc, per, done_cyc, n, a, p, c, x, y;
      bit stop;
      pc = sel ? 2 : 4;
`ifdef PARITY_READER_PREFETCH_EN
      per      = 25;
      done_cyc = 5 + 25 * pc;
`else
      per      = 27;
      done_cyc = 3 + 27 * pc;
`endif
      n = 0; a = 0; stop = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);   // edge 0: start sampled in IDLE
      for (int cyc = 1; cyc <= done_cyc + 1 && !stop; cyc++) begin
         @(negedge clk);
         chk("busy", o_busy, (cyc <= done_cyc));
         chk("done", o_done, (cyc == done_cyc));
         if (o_en) begin
            chk("rd_addr", o_addr, (a == 0) ? pc - 1 : a - 1);
            chk("rd_cycle", cyc, (a == 0) ? 1 : 3 + per * (a - 1));
            a++;
         end
         if (o_cv) begin
            p = n / 25; c = n % 25; y = c / 5; x = c % 5;
            chk("cell_cycle", cyc, 5 + per * p + c);
            if (p < pc) begin
               chk("cur_page",  o_cur,  get_page(p));
               chk("prev_page", o_prev, get_page((p + pc - 1) % pc));
               chk("x_cur",     o_xc, x);
               chk("y_cur",     o_y,  y);
               chk("x_prev",    o_xp, (x + 4) % 5);
               chk("x_next",    o_xn, (x + 1) % 5);
               chk("page_done", o_pd, (c == 24));
            end
            n++;
            if (inject == 2 && p == 2 && c == 10) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               check_idle("rst_mid", 1'b1);
               stop = 1;
            end
         end
         if (!o_cv) chk("pd_without_cv", o_pd, 0);
         start = (inject == 1 && cyc == 5 + per + 3);
      end
      if (!stop) begin
         chk("n_cells", n, 25 * pc);
         chk("n_reads", a, pc + 1);
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_busy", o_busy, 0);
         chk("post_done", o_done, 0);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; start = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset_a", 1'b1);
      sel = 1'b1;
      #1;
      check_idle("reset_b", 1'b1);
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Full pass with one-hot pages.
      for (int k = 0; k < 4; k++) mem_a[k] = 25'd1 << k;
      run_pass(0);

      // Random pages, start pulsed mid-pass must be ignored.
      for (int k = 0; k < 4; k++) mem_a[k] = 25'($urandom);
      run_pass(1);

      // Reset in page 2, then a fresh pass reproduces the first stream.
      for (int k = 0; k < 4; k++) mem_a[k] = 25'd1 << k;
      run_pass(2);
      run_pass(0);

      // Two-page block with random data.
      sel = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 2; k++) mem_b[k] = 25'($urandom);
         run_pass(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
